updown_counter_param: RTL and testbench
=======================================

Name: updown_counter_param

Overview:
Parametrised synchronous up/down counter. It generalises the team's 4-bit up/down counter with:
- configurable width and modulus
- a programmable step
- parallel load
- count enable
- wrap or saturate mode
- terminal-count pulses and a sticky overflow flag

It is used as a general event, timer and address counter in datapath and control blocks. All outputs are registered.

Parameters:
WIDTH, 8, counter width in bits (>= 2).
MAX_VAL, 2**WIDTH-1, highest legal count; counting is modulo MAX_VAL+1. Elaboration requires MAX_VAL <= 2**WIDTH-1 and MAX_VAL >= 1.
STEP_W, 4, width of step input. Elaboration requires 2**STEP_W-1 <= MAX_VAL.
SATURATE, 0, 0 = wrap at limits; 1 = clamp at 0 / MAX_VAL.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  synchronous reset, active-high.
en  in  1  count enable.
up  in  1  direction: 1 = increment, 0 = decrement.
step  in  STEP_W  increment/decrement amount per enabled cycle.
load  in  1  parallel load strobe.
load_val  in  WIDTH  value to load.
clr_ovf  in  1  clears ovf_sticky.
count  out  WIDTH  current count.
tc_up  out  1  one-cycle pulse: upward limit crossed or hit.
tc_dn  out  1  one-cycle pulse: downward limit crossed or hit.
at_max  out  1  count == MAX_VAL.
at_min  out  1  count == 0.
ovf_sticky  out  1  set by any tc_up/tc_dn event; held until cleared.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values on the first posedge with rst=1: count=0, tc_up=0, tc_dn=0, at_max=0 (1 only if MAX_VAL==0, which is illegal), at_min=1, ovf_sticky=0.
- Priority per cycle is rst > load > en. Inputs are sampled on posedge and results are visible after that edge (latency 1).
- Load:
  - count <= min(load_val, MAX_VAL); values above MAX_VAL clamp to MAX_VAL.
  - tc_up and tc_dn are 0 on a load cycle.
  - load works regardless of en.
- Hold: en=0 and load=0, or en=1 with step=0 → count unchanged, tc_up=tc_dn=0.
- Up (en=1, up=1, step=s>0), arithmetic done at WIDTH+1 bits, no truncation before compare:
  - If count+s <= MAX_VAL: count <= count+s, tc_up=0.
  - Else, wrap mode: count <= count+s-(MAX_VAL+1), tc_up=1.
  - Else, saturate mode: count <= MAX_VAL, tc_up=1. This includes the case where count already equals MAX_VAL, so tc_up re-pulses every enabled cycle while pinned.
- Down (en=1, up=0, step=s>0):
  - If count >= s: count <= count-s, tc_dn=0.
  - Else, wrap mode: count <= count+(MAX_VAL+1)-s, tc_dn=1.
  - Else, saturate mode: count <= 0, tc_dn=1.
- The step constraint guarantees one correction suffices; no multi-wrap case exists.
- tc_up and tc_dn are registered. Each is high for exactly the cycle in which the new count is presented, and they are never high together.
- at_max and at_min are decoded from the registered count. They must equal the comparison against the current count output.
- ovf_sticky:
  - Set when the next-state tc_up or tc_dn is 1.
  - Cleared by clr_ovf.
  - If set and clear occur in the same cycle, set wins.
  - rst clears it.
- Reset mid-count: rst overrides any simultaneous load or en, and all outputs return to their reset values after that edge.
- Direction change takes effect on the next enabled edge. There is no dead cycle and no internal state other than count, the tc registers and ovf_sticky.

Test Plan:
1. Decade wrap (WIDTH=4, MAX_VAL=9, SATURATE=0): rst, then en=1, up=1, step=1 for 12 cycles → count 1..9,0,1,2. tc_up high only on the cycle count shows 0. at_max high when count=9. ovf_sticky=1 from then on.
2. Down wrap with step (same config): load_val=2, then up=0, step=3, en=1 → count 9 with tc_dn=1; next cycle count 6 with tc_dn=0.
3. Saturate (WIDTH=8, MAX_VAL=200, SATURATE=1): load 198, up, step=5 for 2 cycles → count 200, 200. tc_up=1 on both cycles, at_max=1. Then up=0, step=15 from load 10 → count 0, tc_dn=1, at_min=1.
4. Priority: on one edge assert rst=1, load=1 (load_val=7) and en=1 → count=0, ovf_sticky=0. Next edge with load=1, load_val=255 while MAX_VAL=200 → count=200, no tc pulse.
5. Sticky flag: provoke a wrap while clr_ovf=1 in the same cycle → ovf_sticky=1. Next cycle with clr_ovf=1 and no event → ovf_sticky=0.
6. Hold cases: en=0 for 5 cycles, then en=1 with step=0 for 5 cycles → count constant, no tc pulses. A direction toggle each cycle with step=1 from count=4 gives 5,4,5,4.

Source files
------------

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter: load, step, wrap/saturate, terminal-count pulses, sticky overflow.
// Latency 1 cycle, every output registered; no backpressure (acts on each cycle's inputs).
module updown_counter_param #(
   parameter int WIDTH     = 8,
   parameter int MAX_VAL   = 2**WIDTH - 1,
   parameter int STEP_W    = 4,
   parameter int SATURATE  = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              up,
   input  logic [STEP_W-1:0] step,
   input  logic              load,
   input  logic [WIDTH-1:0]  load_val,
   input  logic              clr_ovf,
   output logic [WIDTH-1:0]  count,
   output logic              tc_up,
   output logic              tc_dn,
   output logic              at_max,
   output logic              at_min,
   output logic              ovf_sticky
);

   if (WIDTH < 2) begin : g_bad_width
      $error("updown_counter_param: WIDTH must be >= 2");
   end
   if (MAX_VAL < 1 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_max
      $error("updown_counter_param: MAX_VAL must be in 1..2**WIDTH-1");
   end
   if (2**STEP_W - 1 > MAX_VAL) begin : g_bad_step
      $error("updown_counter_param: 2**STEP_W-1 must not exceed MAX_VAL");
   end

   // One guard bit so the limit compare sees the untruncated sum.
   localparam logic [WIDTH:0] MAX_EXT = (WIDTH+1)'(MAX_VAL);
   localparam logic [WIDTH:0] MOD_EXT = MAX_EXT + {{WIDTH{1'b0}}, 1'b1};

   logic [WIDTH:0]   count_ext;
   logic [WIDTH:0]   step_ext;
   logic [WIDTH:0]   load_ext;
   logic [WIDTH:0]   sum_up;
   logic [WIDTH:0]   wrap_up;
   logic [WIDTH:0]   diff_dn;
   logic [WIDTH:0]   wrap_dn;
   logic [WIDTH-1:0] count_nxt;
   logic             tc_up_nxt;
   logic             tc_dn_nxt;

   assign count_ext = {1'b0, count};
   assign step_ext  = (WIDTH+1)'(step);
   assign load_ext  = {1'b0, load_val};
   assign sum_up    = count_ext + step_ext;
   assign wrap_up   = sum_up - MOD_EXT;
   assign diff_dn   = count_ext - step_ext;
   assign wrap_dn   = (MOD_EXT - step_ext) + count_ext;

   always_comb begin
      count_nxt = count;
      tc_up_nxt = 1'b0;
      tc_dn_nxt = 1'b0;
      if (load) begin
         count_nxt = (load_ext > MAX_EXT) ? MAX_EXT[WIDTH-1:0] : load_val;
      end else if (en && (step != '0)) begin
         if (up) begin
            if (sum_up > MAX_EXT) begin
               tc_up_nxt = 1'b1;
               count_nxt = (SATURATE != 0) ? MAX_EXT[WIDTH-1:0] : wrap_up[WIDTH-1:0];
            end else begin
               count_nxt = sum_up[WIDTH-1:0];
            end
         end else begin
            if (count_ext >= step_ext) begin
               count_nxt = diff_dn[WIDTH-1:0];
            end else begin
               tc_dn_nxt = 1'b1;
               count_nxt = (SATURATE != 0) ? '0 : wrap_dn[WIDTH-1:0];
            end
         end
      end
   end

   // Limit flags are decoded from the next count so they line up with the registered count.
   always_ff @(posedge clk) begin
      if (rst) begin
         count      <= '0;
         tc_up      <= 1'b0;
         tc_dn      <= 1'b0;
         at_max     <= 1'b0;
         at_min     <= 1'b1;
         ovf_sticky <= 1'b0;
      end else begin
         count  <= count_nxt;
         tc_up  <= tc_up_nxt;
         tc_dn  <= tc_dn_nxt;
         at_max <= ({1'b0, count_nxt} == MAX_EXT);
         at_min <= (count_nxt == '0);
         if (tc_up_nxt || tc_dn_nxt) begin
            ovf_sticky <= 1'b1;
         end else if (clr_ovf) begin
            ovf_sticky <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_updown_counter_param.sv
// Bench for updown_counter_param: three configurations (decade wrap, 0..200 saturate,
// full 8-bit wrap) share one stimulus stream and are compared against an integer model.
module tb_updown_counter_param;

   logic       clk = 1'b0;
   logic       rst, en, up, load, clr_ovf;
   logic [3:0] step;
   logic [7:0] load_val;

   logic [3:0] a_count;
   logic       a_tcu, a_tcd, a_amax, a_amin, a_ovf;
   logic [7:0] b_count;
   logic       b_tcu, b_tcd, b_amax, b_amin, b_ovf;
   logic [7:0] c_count;
   logic       c_tcu, c_tcd, c_amax, c_amin, c_ovf;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int cnt;
      bit tcu;
      bit tcd;
      bit ovf;
   } mstate_t;

   mstate_t ma, mb, mc;

   always #5 clk = ~clk;

   updown_counter_param #(.WIDTH(4), .MAX_VAL(9), .STEP_W(3), .SATURATE(0)) u_a (
      .clk(clk), .rst(rst), .en(en), .up(up), .step(step[2:0]), .load(load),
      .load_val(load_val[3:0]), .clr_ovf(clr_ovf), .count(a_count), .tc_up(a_tcu),
      .tc_dn(a_tcd), .at_max(a_amax), .at_min(a_amin), .ovf_sticky(a_ovf));

   updown_counter_param #(.WIDTH(8), .MAX_VAL(200), .STEP_W(4), .SATURATE(1)) u_b (
      .clk(clk), .rst(rst), .en(en), .up(up), .step(step), .load(load),
      .load_val(load_val), .clr_ovf(clr_ovf), .count(b_count), .tc_up(b_tcu),
      .tc_dn(b_tcd), .at_max(b_amax), .at_min(b_amin), .ovf_sticky(b_ovf));

   updown_counter_param #(.WIDTH(8), .MAX_VAL(255), .STEP_W(4), .SATURATE(0)) u_c (
      .clk(clk), .rst(rst), .en(en), .up(up), .step(step), .load(load),
      .load_val(load_val), .clr_ovf(clr_ovf), .count(c_count), .tc_up(c_tcu),
      .tc_dn(c_tcd), .at_max(c_amax), .at_min(c_amin), .ovf_sticky(c_ovf));

   // Reference: counting rules stated directly as integer arithmetic on the count value.
   function automatic mstate_t mnext(mstate_t s, int maxv, bit sat, int st, int lv);
      mstate_t n;
      n = s;
      n.tcu = 1'b0;
      n.tcd = 1'b0;
      if (rst) begin
         n.cnt = 0;
         n.ovf = 1'b0;
         return n;
      end
      if (load) begin
         n.cnt = (lv > maxv) ? maxv : lv;
      end else if (en && st > 0) begin
         if (up) begin
            if (s.cnt + st > maxv) begin
               n.tcu = 1'b1;
               n.cnt = sat ? maxv : s.cnt + st - (maxv + 1);
            end else begin
               n.cnt = s.cnt + st;
            end
         end else begin
            if (s.cnt >= st) begin
               n.cnt = s.cnt - st;
            end else begin
               n.tcd = 1'b1;
               n.cnt = sat ? 0 : s.cnt + (maxv + 1) - st;
            end
         end
      end
      if (n.tcu || n.tcd) n.ovf = 1'b1;
      else if (clr_ovf) n.ovf = 1'b0;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic check_dut(input string nm, input logic [31:0] cnt, input logic tu,
                            input logic td, input logic amx, input logic amn,
                            input logic ov, input mstate_t m, input int maxv);
      chk({nm, ".count"},  cnt, m.cnt);
      chk({nm, ".tc_up"},  {31'd0, tu},  {31'd0, m.tcu});
      chk({nm, ".tc_dn"},  {31'd0, td},  {31'd0, m.tcd});
      chk({nm, ".at_max"}, {31'd0, amx}, (m.cnt == maxv) ? 32'd1 : 32'd0);
      chk({nm, ".at_min"}, {31'd0, amn}, (m.cnt == 0) ? 32'd1 : 32'd0);
      chk({nm, ".ovf"},    {31'd0, ov},  {31'd0, m.ovf});
   endtask

   // One clock: DUTs and models consume the held inputs, outputs are sampled 1 time unit later.
   task automatic cyc();
      @(posedge clk);
      ma = mnext(ma, 9,   1'b0, int'(step[2:0]), int'(load_val[3:0]));
      mb = mnext(mb, 200, 1'b1, int'(step),      int'(load_val));
      mc = mnext(mc, 255, 1'b0, int'(step),      int'(load_val));
      #1;
      check_dut("A", {28'd0, a_count}, a_tcu, a_tcd, a_amax, a_amin, a_ovf, ma, 9);
      check_dut("B", {24'd0, b_count}, b_tcu, b_tcd, b_amax, b_amin, b_ovf, mb, 200);
      check_dut("C", {24'd0, c_count}, c_tcu, c_tcd, c_amax, c_amin, c_ovf, mc, 255);
   endtask

   task automatic drive(input logic r, input logic e, input logic u, input logic [3:0] s,
                        input logic l, input logic [7:0] lv, input logic c);
      rst = r; en = e; up = u; step = s; load = l; load_val = lv; clr_ovf = c;
   endtask

   initial begin
      ma = '{0, 1'b0, 1'b0, 1'b0};
      mb = ma;
      mc = ma;
      drive(1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 8'd0, 1'b0);
      #2;
      cyc();
      chk("reset.a_count", {28'd0, a_count}, 32'd0);
      chk("reset.a_at_min", {31'd0, a_amin}, 32'd1);

      // Decade wrap: 1..9,0,1,2
      drive(1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 8'd0, 1'b0);
      for (int i = 1; i <= 12; i++) begin
         cyc();
         chk("dec.count", {28'd0, a_count}, i % 10);
         chk("dec.tc_up", {31'd0, a_tcu}, (i == 10) ? 32'd1 : 32'd0);
         chk("dec.at_max", {31'd0, a_amax}, (i == 9) ? 32'd1 : 32'd0);
         chk("dec.ovf", {31'd0, a_ovf}, (i >= 10) ? 32'd1 : 32'd0);
      end

      // Down wrap with step 3 from 2
      drive(1'b0, 1'b0, 1'b0, 4'd3, 1'b1, 8'd2, 1'b0);
      cyc();
      drive(1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 8'd0, 1'b0);
      cyc();
      chk("dnwrap.count", {28'd0, a_count}, 32'd9);
      chk("dnwrap.tc_dn", {31'd0, a_tcd}, 32'd1);
      cyc();
      chk("dnwrap2.count", {28'd0, a_count}, 32'd6);
      chk("dnwrap2.tc_dn", {31'd0, a_tcd}, 32'd0);

      // Saturate at 200, re-pulse while pinned, then saturate at 0
      drive(1'b0, 1'b0, 1'b1, 4'd5, 1'b1, 8'd198, 1'b0);
      cyc();
      drive(1'b0, 1'b1, 1'b1, 4'd5, 1'b0, 8'd0, 1'b0);
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("sat.count", {24'd0, b_count}, 32'd200);
         chk("sat.tc_up", {31'd0, b_tcu}, 32'd1);
         chk("sat.at_max", {31'd0, b_amax}, 32'd1);
      end
      drive(1'b0, 1'b0, 1'b0, 4'd15, 1'b1, 8'd10, 1'b0);
      cyc();
      drive(1'b0, 1'b1, 1'b0, 4'd15, 1'b0, 8'd0, 1'b0);
      cyc();
      chk("satdn.count", {24'd0, b_count}, 32'd0);
      chk("satdn.tc_dn", {31'd0, b_tcd}, 32'd1);
      chk("satdn.at_min", {31'd0, b_amin}, 32'd1);

      // Priority rst > load > en, then load clamp
      drive(1'b1, 1'b1, 1'b1, 4'd1, 1'b1, 8'd7, 1'b0);
      cyc();
      chk("prio.count", {24'd0, b_count}, 32'd0);
      chk("prio.ovf", {31'd0, b_ovf}, 32'd0);
      drive(1'b0, 1'b1, 1'b1, 4'd1, 1'b1, 8'd255, 1'b0);
      cyc();
      chk("clamp.count", {24'd0, b_count}, 32'd200);
      chk("clamp.tc_up", {31'd0, b_tcu}, 32'd0);
      chk("clamp.a_count", {28'd0, a_count}, 32'd9);

      // Sticky: set beats simultaneous clear, then clear alone
      drive(1'b0, 1'b1, 1'b1, 4'd1, 1'b0, 8'd0, 1'b1);
      cyc();
      chk("sticky.set", {31'd0, a_ovf}, 32'd1);
      chk("sticky.a_count", {28'd0, a_count}, 32'd0);
      drive(1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 8'd0, 1'b1);
      cyc();
      chk("sticky.clr", {31'd0, a_ovf}, 32'd0);

      // Hold with en=0 and with step=0, then direction toggle
      drive(1'b0, 1'b0, 1'b1, 4'd1, 1'b1, 8'd4, 1'b0);
      cyc();
      for (int i = 0; i < 10; i++) begin
         drive(1'b0, (i >= 5), 1'b1, (i >= 5) ? 4'd0 : 4'd3, 1'b0, 8'd0, 1'b0);
         cyc();
         chk("hold.count", {28'd0, a_count}, 32'd4);
         chk("hold.tc", {31'd0, a_tcu | a_tcd}, 32'd0);
      end
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, (i % 2 == 0), 4'd1, 1'b0, 8'd0, 1'b0);
         cyc();
         chk("toggle.count", {28'd0, a_count}, (i % 2 == 0) ? 32'd5 : 32'd4);
      end

      // Random traffic against the model
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
               4'($urandom), ($urandom_range(0, 7) == 0), 8'($urandom),
               ($urandom_range(0, 5) == 0));
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
